pu_output_arbiter: RTL and testbench
====================================

# pu_output_arbiter

Shares the single output-memory write port among `NUM_PU` processing units. Grants one PU at a time in round-robin order and packs that PU's 32-bit `output_word` stream into 512-bit blocks. Each block is written to a fixed per-PU region with a one-beat address/data transaction, and `finished` is raised once every PU has delivered all `NUM_OUTPUTS` words. It sits between the PU array's output side and the `outputMem*` ports of the streaming wrapper.

## Interface
- `NUM_PU`, default 4: number of processing units; ≥1.
- `NUM_OUTPUTS`, default 32: 32-bit words each PU emits; ≥1. Blocks per PU `B = ceil(NUM_OUTPUTS/16)`.
- `clock` in 1: single clock; all logic is posedge.
- `reset` in 1: asynchronous, active-high.
- `output_base` in 64: byte address of the output region; held stable while running.
- `output_word` in `NUM_PU*32`: PU i's word is bits `[32i+31:32i]`.
- `output_valid` in `NUM_PU`: per-PU word valid.
- `output_ready` out `NUM_PU`: per-PU word accept; at most one bit set.
- `outputMemAddr` out 64: write byte address.
- `outputMemAddrValid` out 1: address request valid.
- `outputMemAddrLen` out 8: beats minus one; always 0.
- `outputMemAddrId` out 16: granted PU index, zero-extended.
- `outputMemAddrReady` in 1: address accept.
- `outputMemBlock` out 512: data beat; word w is bits `[32w+31:32w]`.
- `outputMemBlockValid` out 1: data valid.
- `outputMemBlockLast` out 1: equals `outputMemBlockValid`.
- `outputMemBlockReady` in 1: data accept.
- `finished` out 1: all blocks of all PUs written; sticky until reset.

## Operation
- Per-PU state:
  - `blk_cnt[i]`: 0..B, number of blocks written.
  - `word_cnt[i]`: 0..NUM_OUTPUTS, number of words accepted.
  - PU i is complete when `blk_cnt[i]==B`.
- Global state: `grant` (PU index), `rr_ptr`, 512-bit `buffer`, 4-bit lane index `lane`.
- FSM states: SELECT, FILL, SEND_ADDR, SEND_DATA, DONE.
- SELECT:
  - If all PUs are complete, go to DONE.
  - Otherwise, search from `rr_ptr` upward with wrap-around and grant the first incomplete PU with `output_valid=1`. Set `lane=0`, clear `buffer`, go to FILL.
  - If no candidate exists, stay in SELECT.
- FILL:
  - `output_ready[grant]=1`, driven from state only and independent of `output_valid`.
  - On each handshake, write the word to lane `lane`, then increment `lane` and `word_cnt[grant]`.
  - The block closes on the handshake where `lane==15` or `word_cnt[grant]` reaches NUM_OUTPUTS. The next state is SEND_ADDR.
  - The grant is held while `output_valid` is low; no other PU is served.
- SEND_ADDR:
  - Drive `outputMemAddr = output_base + (grant*B + blk_cnt[grant])*64`, computed in 64 bits with wrap on overflow.
  - Hold `outputMemAddrValid` and all address fields stable until `outputMemAddrReady`, then go to SEND_DATA.
- SEND_DATA:
  - `outputMemBlock = buffer`. Unfilled lanes of a partial final block are zero.
  - Hold `outputMemBlockValid` and `outputMemBlockLast` high until `outputMemBlockReady`.
  - On acceptance: increment `blk_cnt[grant]`, set `rr_ptr = (grant+1) mod NUM_PU`, go to SELECT.
- DONE: `finished=1` and all `output_ready` bits are 0. Leave only on reset.
- A complete PU never sees `output_ready`; any extra words it presents are ignored.

## Timing
- Reset values: all outputs are 0, including `output_ready`, `outputMemAddr`, `outputMemAddrId` and `outputMemBlock`. FSM goes to SELECT; `rr_ptr=0`, all counters are 0.
- Reset mid-operation clears everything immediately, without waiting for a clock edge. The partial buffer and any in-flight request are discarded.
- SELECT costs 1 cycle.
- FILL accepts up to 1 word per cycle.
- SEND_ADDR and SEND_DATA each take at least 1 cycle; the handshake completes on the rising edge where valid and ready are both 1.
- Address and data are never valid in the same cycle.
- Full block, no backpressure: 1 + 16 + 1 + 1 = 19 cycles.
- `finished` rises the cycle after the SEND_DATA→SELECT transition that finds every PU complete (SELECT→DONE).

## Test plan
- NUM_PU=2, NUM_OUTPUTS=16, base=0x1000; PU0 sends 0..15, PU1 sends 0x100..0x10F, all valid from cycle 0:
  - Writes: addr 0x1000 with id 0, then addr 0x1040 with id 1; lanes match the words in order; len 0 and last=1 on both.
  - `finished` rises; the first data handshake happens 19 cycles after reset deassertion.
- NUM_PU=1, NUM_OUTPUTS=20, base=0:
  - Block 0 at 0x0 holds words 0..15.
  - Block 1 at 0x40 has words 16..19 in lanes 0..3 and lanes 4..15 zero. Then `finished`.
- NUM_PU=2, NUM_OUTPUTS=32, both PUs always valid:
  - Write order is PU0 blk0 (0x0), PU1 blk0 (0x80), PU0 blk1 (0x40), PU1 blk1 (0xC0).
- Backpressure:
  - Hold `outputMemAddrReady` low for 5 cycles, then `outputMemBlockReady` low for 3 cycles.
  - Addr, id and block stay stable; `output_ready` stays all-zero; exactly one write per block.
- PU0 drops `output_valid` for 4 cycles mid-block while PU1 is valid:
  - Grant stays on PU0 and PU1 gets no ready; the block completes with no lane gaps.
- Assert `reset` asynchronously between clock edges during FILL (lane 7), hold 2 cycles, release:
  - All outputs go 0 immediately.
  - On restart, the first write goes to block 0 of PU0 at `output_base`.

Source files
------------

// File: rtl/pu_output_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : pu_output_arbiter_if
// Purpose  : Bundles the PU word streams and the output-memory write port
//            seen by pu_output_arbiter.
// Ports    : master - arbiter view (drives output_ready, outputMem*, finished)
//            slave  - environment view (drives PU words, base, memory readies)
// Revision : 1.0 - initial release
// ============================================================================
interface pu_output_arbiter_if #(
  parameter int NUM_PU = 4
);
  // PU side
  logic [63:0]          output_base;
  logic [NUM_PU*32-1:0] output_word;
  logic [NUM_PU-1:0]    output_valid;
  logic [NUM_PU-1:0]    output_ready;
  // memory address channel
  logic [63:0]          outputMemAddr;
  logic                 outputMemAddrValid;
  logic [7:0]           outputMemAddrLen;
  logic [15:0]          outputMemAddrId;
  logic                 outputMemAddrReady;
  // memory data channel
  logic [511:0]         outputMemBlock;
  logic                 outputMemBlockValid;
  logic                 outputMemBlockLast;
  logic                 outputMemBlockReady;
  // status
  logic                 finished;

  modport master (
    input  output_base, output_word, output_valid,
    input  outputMemAddrReady, outputMemBlockReady,
    output output_ready,
    output outputMemAddr, outputMemAddrValid, outputMemAddrLen, outputMemAddrId,
    output outputMemBlock, outputMemBlockValid, outputMemBlockLast,
    output finished
  );

  modport slave (
    output output_base, output_word, output_valid,
    output outputMemAddrReady, outputMemBlockReady,
    input  output_ready,
    input  outputMemAddr, outputMemAddrValid, outputMemAddrLen, outputMemAddrId,
    input  outputMemBlock, outputMemBlockValid, outputMemBlockLast,
    input  finished
  );
endinterface
`default_nettype wire

// File: rtl/pu_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pu_output_arbiter
// Purpose  : Round-robin owner of the single output-memory write port. Packs
//            the granted PU's 32-bit words into 512-bit blocks and writes each
//            block to that PU's fixed region with a single-beat transaction.
//            Raises finished once every PU has delivered all its words.
// Ports    : clock  - rising-edge clock
//            reset  - asynchronous, active-high
//            bus    - pu_output_arbiter_if.master (PU streams + memory port)
// Revision : 1.0 - initial release
// ============================================================================
module pu_output_arbiter #(
  parameter int NUM_PU      = 4,
  parameter int NUM_OUTPUTS = 32
) (
  input  wire logic            clock,
  input  wire logic            reset,
  pu_output_arbiter_if.master  bus
);

  localparam int BLOCKS = (NUM_OUTPUTS + 15) / 16;
  localparam int PU_W   = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;
  localparam int BLK_W  = $clog2(BLOCKS + 1);
  localparam int WORD_W = $clog2(NUM_OUTPUTS + 1);

  localparam logic [2:0] S_SELECT    = 3'd0;
  localparam logic [2:0] S_FILL      = 3'd1;
  localparam logic [2:0] S_SEND_ADDR = 3'd2;
  localparam logic [2:0] S_SEND_DATA = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic [PU_W-1:0]   r_grant;
  logic [PU_W-1:0]   r_rr_ptr;
  logic [511:0]      r_buffer;
  logic [3:0]        r_lane;
  logic [BLK_W-1:0]  r_blk_cnt  [NUM_PU];
  logic [WORD_W-1:0] r_word_cnt [NUM_PU];

  logic [NUM_PU-1:0] w_complete;
  logic              w_all_complete;
  logic              w_found;
  logic [PU_W-1:0]   w_pick;
  logic [PU_W:0]     w_cand;
  logic [31:0]       w_grant_word;
  logic              w_grant_valid;
  logic [WORD_W-1:0] w_grant_words;
  logic [BLK_W-1:0]  w_grant_blks;
  logic              w_word_hs;
  logic              w_block_close;
  logic              w_addr_hs;
  logic              w_data_hs;
  logic [63:0]       w_addr;

  // --------------------------------------------------------------------------
  // Per-PU progress counters
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_PU; gi++) begin : g_pu
      assign w_complete[gi] = (r_blk_cnt[gi] == BLK_W'(BLOCKS));

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_blk_cnt[gi]  <= '0;
          r_word_cnt[gi] <= '0;
        end else begin
          if (w_word_hs && (r_grant == PU_W'(gi)))
            r_word_cnt[gi] <= r_word_cnt[gi] + WORD_W'(1);
          if (w_data_hs && (r_grant == PU_W'(gi)))
            r_blk_cnt[gi] <= r_blk_cnt[gi] + BLK_W'(1);
        end
      end
    end
  endgenerate

  assign w_all_complete = &w_complete;

  // Round-robin search: offsets are visited in increasing order starting at
  // r_rr_ptr, so the first hit is the nearest eligible PU after the pointer.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_PU; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (PU_W+1)'(k);
      if (w_cand >= (PU_W+1)'(NUM_PU))
        w_cand = w_cand - (PU_W+1)'(NUM_PU);
      if (!w_found && bus.output_valid[w_cand[PU_W-1:0]] && !w_complete[w_cand[PU_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[PU_W-1:0];
      end
    end
  end

  // Granted-PU views of the per-PU signals
  always_comb begin
    w_grant_word  = '0;
    w_grant_valid = 1'b0;
    w_grant_words = '0;
    w_grant_blks  = '0;
    for (int i = 0; i < NUM_PU; i++) begin
      if (r_grant == PU_W'(i)) begin
        w_grant_word  = bus.output_word[i*32 +: 32];
        w_grant_valid = bus.output_valid[i];
        w_grant_words = r_word_cnt[i];
        w_grant_blks  = r_blk_cnt[i];
      end
    end
  end

  assign w_word_hs     = (r_state == S_FILL) && w_grant_valid;
  // Block ends on a full lane set or on this PU's final word (partial block)
  assign w_block_close = (r_lane == 4'd15) || (w_grant_words == WORD_W'(NUM_OUTPUTS - 1));
  assign w_addr_hs     = (r_state == S_SEND_ADDR) && bus.outputMemAddrReady;
  assign w_data_hs     = (r_state == S_SEND_DATA) && bus.outputMemBlockReady;

  // Region of PU g starts at block g*BLOCKS; 64-bit arithmetic wraps naturally
  assign w_addr = bus.output_base +
                  ((64'(r_grant) * 64'(BLOCKS) + 64'(w_grant_blks)) << 6);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_SELECT;
    else       r_state <= w_next_state;
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_SELECT: begin
        if (w_all_complete) w_next_state = S_DONE;
        else if (w_found)   w_next_state = S_FILL;
      end
      S_FILL:      if (w_word_hs && w_block_close) w_next_state = S_SEND_ADDR;
      S_SEND_ADDR: if (w_addr_hs)                  w_next_state = S_SEND_DATA;
      S_SEND_DATA: if (w_data_hs)                  w_next_state = S_SELECT;
      S_DONE:      w_next_state = S_DONE;
      default:     w_next_state = S_SELECT;
    endcase
  end

  // --------------------------------------------------------------------------
  // Grant, round-robin pointer and block buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_buffer <= '0;
      r_lane   <= '0;
    end else begin
      case (r_state)
        S_SELECT: begin
          if (!w_all_complete && w_found) begin
            r_grant  <= w_pick;
            r_lane   <= '0;
            r_buffer <= '0;
          end
        end
        S_FILL: begin
          if (w_word_hs) begin
            r_buffer[{r_lane, 5'b00000} +: 32] <= w_grant_word;
            r_lane                             <= r_lane + 4'd1;
          end
        end
        S_SEND_DATA: begin
          if (w_data_hs)
            r_rr_ptr <= (r_grant == PU_W'(NUM_PU - 1)) ? '0 : r_grant + PU_W'(1);
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (pure function of state, so reset zeroes them at once)
  // --------------------------------------------------------------------------
  always_comb begin
    bus.output_ready        = '0;
    bus.outputMemAddr       = '0;
    bus.outputMemAddrValid  = 1'b0;
    bus.outputMemAddrLen    = 8'd0;
    bus.outputMemAddrId     = '0;
    bus.outputMemBlock      = '0;
    bus.outputMemBlockValid = 1'b0;
    bus.outputMemBlockLast  = 1'b0;
    bus.finished            = 1'b0;
    case (r_state)
      S_FILL: begin
        for (int i = 0; i < NUM_PU; i++)
          bus.output_ready[i] = (r_grant == PU_W'(i));
      end
      S_SEND_ADDR: begin
        bus.outputMemAddrValid = 1'b1;
        bus.outputMemAddr      = w_addr;
        bus.outputMemAddrId    = 16'(r_grant);
      end
      S_SEND_DATA: begin
        bus.outputMemBlockValid = 1'b1;
        bus.outputMemBlockLast  = 1'b1;
        bus.outputMemBlock      = r_buffer;
      end
      S_DONE:  bus.finished = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pu_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pu_output_arbiter
// Purpose  : Self-checking bench for pu_output_arbiter (3 PUs, 20 words each,
//            so every PU has one full and one partial block).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pu_output_arbiter;
  localparam int NP = 3;
  localparam int NO = 20;
  localparam int NB = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pu_output_arbiter_if #(.NUM_PU(NP)) bus ();
  pu_output_arbiter #(.NUM_PU(NP), .NUM_OUTPUTS(NO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- stimulus state ----------------
  logic [63:0] base;
  int  pu_cnt  [NP];
  bit  pu_pend [NP];
  int  drop_left;
  bit  bp_mode;
  int  a_stall, d_stall;
  int  rel_cyc;

  // ---------------- model / scoreboard state ----------------
  int           m_blk [NP];
  int           m_rr;
  bit           m_addr_done;
  int           after_cnt;
  int           n_wr;
  int           a_stalls, d_stalls;
  int           first_hs_cyc;
  logic [63:0]  log_addr [8];
  int           log_id   [8];
  logic [511:0] log_blk  [8];

  function automatic logic [31:0] word_of(int p, int k);
    return {16'(p + 1), 16'(k)};
  endfunction

  // Block j of PU p: words 16j.. in lane order, missing words are zero
  function automatic logic [511:0] block_of(int p, int j);
    logic [511:0] b;
    b = '0;
    for (int w = 0; w < 16; w++)
      if (16 * j + w < NO) b[32*w +: 32] = word_of(p, 16 * j + w);
    return b;
  endfunction

  // Next PU to be served: first unfinished PU at or after the pointer
  function automatic int next_pu();
    for (int k = 0; k < NP; k++) begin
      int p;
      p = (m_rr + k) % NP;
      if (m_blk[p] < NB) return p;
    end
    return -1;
  endfunction

  task automatic check(string name, logic [511:0] act, logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NP; i++) m_blk[i] = 0;
    m_rr = 0; m_addr_done = 0; after_cnt = 0; n_wr = 0;
    a_stalls = 0; d_stalls = 0; first_hs_cyc = -1;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    #2;
    if (reset) begin
      check("reset_outputs",
            {bus.output_ready, bus.outputMemAddr, bus.outputMemAddrValid, bus.outputMemAddrLen,
             bus.outputMemAddrId, bus.outputMemBlockValid, bus.outputMemBlockLast, bus.finished}, '0);
      check("reset_block", bus.outputMemBlock, '0);
      model_clear();
    end else begin
      int  p;
      bit  all_done;
      all_done = 1'b1;
      for (int i = 0; i < NP; i++) if (m_blk[i] < NB) all_done = 1'b0;
      if (all_done) after_cnt++;
      check("finished", bus.finished, all_done && after_cnt >= 2);
      check("addr_len", bus.outputMemAddrLen, 0);
      check("block_last", bus.outputMemBlockLast, bus.outputMemBlockValid);
      check("addr_data_overlap", bus.outputMemAddrValid && bus.outputMemBlockValid, 0);
      p = next_pu();
      if (p < 0) begin
        check("idle_after_done", {bus.output_ready, bus.outputMemAddrValid, bus.outputMemBlockValid}, 0);
      end else begin
        if (bus.output_ready != '0)
          check("ready_grant", bus.output_ready, NP'(1) << p);
        if (bus.outputMemAddrValid || bus.outputMemBlockValid)
          check("ready_while_sending", bus.output_ready, 0);
        if (bus.outputMemAddrValid) begin
          check("addr", bus.outputMemAddr, base + 64'((p * NB + m_blk[p]) * 64));
          check("addr_id", bus.outputMemAddrId, 16'(p));
          check("addr_once", m_addr_done, 0);
          if (bus.outputMemAddrReady) m_addr_done = 1'b1;
          else a_stalls++;
        end
        if (bus.outputMemBlockValid) begin
          check("data_after_addr", m_addr_done, 1);
          check("block", bus.outputMemBlock, block_of(p, m_blk[p]));
          if (bus.outputMemBlockReady) begin
            if (n_wr == 0) first_hs_cyc = cyc + 1;
            if (n_wr < 8) begin
              log_addr[n_wr] = base + 64'((p * NB + m_blk[p]) * 64);
              log_id[n_wr]   = p;
              log_blk[n_wr]  = bus.outputMemBlock;
            end
            n_wr++;
            m_blk[p]++;
            m_rr = (p + 1) % NP;
            m_addr_done = 1'b0;
          end else begin
            d_stalls++;
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive_now();
    logic [NP-1:0]    v;
    logic [NP*32-1:0] wd;
    for (int i = 0; i < NP; i++) if (pu_pend[i]) pu_cnt[i]++;
    for (int i = 0; i < NP; i++) begin
      v[i] = 1'b1;
      if (i == 0 && drop_left > 0 && pu_cnt[0] == 5) begin
        v[i] = 1'b0;
        drop_left--;
      end
      wd[32*i +: 32] = word_of(i, pu_cnt[i]);
    end
    bus.output_valid = v;
    bus.output_word  = wd;
    if (bp_mode) begin
      bus.outputMemAddrReady  = !(bus.outputMemAddrValid && a_stall < 5);
      if (bus.outputMemAddrValid && a_stall < 5) a_stall++;
      bus.outputMemBlockReady = !(bus.outputMemBlockValid && d_stall < 3);
      if (bus.outputMemBlockValid && d_stall < 3) d_stall++;
      if (bus.outputMemBlockValid && bus.outputMemBlockReady) begin
        a_stall = 0;
        d_stall = 0;
      end
    end else begin
      bus.outputMemAddrReady  = 1'b1;
      bus.outputMemBlockReady = 1'b1;
    end
    for (int i = 0; i < NP; i++) pu_pend[i] = v[i] && bus.output_ready[i];
  endtask

  task automatic drive_cycle();
    @(negedge clock);
    drive_now();
  endtask

  task automatic clear_driver();
    for (int i = 0; i < NP; i++) begin
      pu_cnt[i]  = 0;
      pu_pend[i] = 1'b0;
    end
    a_stall = 0;
    d_stall = 0;
  endtask

  task automatic start_run(logic [63:0] b, bit bp, int drop);
    reset = 1'b1;
    base = b;
    bus.output_base = b;
    bp_mode = bp;
    drop_left = drop;
    clear_driver();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    rel_cyc = cyc;
    drive_now();
  endtask

  task automatic run_until_done();
    for (int t = 0; t < 800 && !bus.finished; t++) drive_cycle();
    check("finish_timeout", bus.finished, 1);
    repeat (3) drive_cycle();
  endtask

  initial begin
    base = 64'h0;
    bus.output_base         = '0;
    bus.output_word         = '0;
    bus.output_valid        = '0;
    bus.outputMemAddrReady  = 1'b0;
    bus.outputMemBlockReady = 1'b0;
    bp_mode = 1'b0;
    drop_left = 0;
    clear_driver();
    repeat (2) @(negedge clock);

    // Run 1: all PUs valid, no backpressure
    start_run(64'h1000, 1'b0, 0);
    run_until_done();
    check("r1_latency", 32'(first_hs_cyc - rel_cyc), 32'd19);
    check("r1_nwr", n_wr, 6);
    check("r1_addr0", log_addr[0], 64'h1000);
    check("r1_id0", log_id[0], 0);
    check("r1_lane0", log_blk[0][31:0], 32'h0001_0000);
    check("r1_lane15", log_blk[0][511:480], 32'h0001_000F);
    check("r1_addr1", log_addr[1], 64'h1080);
    check("r1_id1", log_id[1], 1);
    check("r1_addr2", log_addr[2], 64'h1100);
    check("r1_addr3", log_addr[3], 64'h1040);
    check("r1_id3", log_id[3], 0);
    check("r1_p0b1_lane3", log_blk[3][127:96], 32'h0001_0013);
    check("r1_p0b1_lane4", log_blk[3][159:128], 32'h0);
    check("r1_p0b1_hi", log_blk[3][511:128], '0);

    // Run 2: memory backpressure on every write, PU0 pauses mid-block
    start_run(64'h0, 1'b1, 4);
    run_until_done();
    check("r2_nwr", n_wr, 6);
    check("r2_addr_stalls", a_stalls, 30);
    check("r2_data_stalls", d_stalls, 18);
    check("r2_p0_lane5", log_blk[0][191:160], 32'h0001_0005);
    check("r2_p0_lane6", log_blk[0][223:192], 32'h0001_0006);
    check("r2_addr4", log_addr[4], 64'hC0);
    check("r2_id4", log_id[4], 1);
    check("r2_addr5", log_addr[5], 64'h140);

    // Run 3: asynchronous reset while PU0's first block holds 7 words
    start_run(64'h2000, 1'b0, 0);
    for (int t = 0; t < 100 && pu_cnt[0] != 7; t++) drive_cycle();
    check("r3_reached_lane7", pu_cnt[0], 7);
    #3;
    reset = 1'b1;
    #1;
    check("r3_async_zero",
          {bus.output_ready, bus.outputMemAddrValid, bus.outputMemBlockValid, bus.finished,
           bus.outputMemAddr, bus.outputMemAddrId}, '0);
    check("r3_async_block", bus.outputMemBlock, '0);
    clear_driver();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    drive_now();
    run_until_done();
    check("r3_nwr", n_wr, 6);
    check("r3_addr0", log_addr[0], 64'h2000);
    check("r3_id0", log_id[0], 0);
    check("r3_lane7", log_blk[0][255:224], 32'h0001_0007);
    check("r3_lane8", log_blk[0][287:256], 32'h0001_0008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
